sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Sequential arbiter that shares the single SRAM controller port between the bootloader write port, the processor instruction-fetch port and the processor data port. It sits between those requesters and `sram_fsm`, replacing the static `boot_mode` mux with a request/acknowledge handshake, round-robin fairness between instruction and data traffic, and a bus-hang watchdog. One transaction is in flight at a time.

## Interface
- DATA_WIDTH, 32, width of all data buses
- ADDR_WIDTH, 20, width of all address buses
- TIMEOUT_CYCLES, 255, max BUSY cycles before watchdog abort (>=2, counter width $clog2(TIMEOUT_CYCLES+1))

- clk  in  1  single clock for the whole block
- rst_n  in  1  reset, asynchronous assert, active-low
- boot_mode  in  1  1 = only boot port served; 0 = only inst/data ports served
- boot_req / boot_addr / boot_wr_data  in  1 / ADDR_WIDTH / DATA_WIDTH  boot write request (write-only)
- boot_ack  out  1  one-cycle completion pulse
- inst_req / inst_addr  in  1 / ADDR_WIDTH  instruction read request
- inst_rd_data  out  DATA_WIDTH  read data, registered, valid while inst_ack=1
- inst_ack  out  1  one-cycle completion pulse
- data_req / data_we / data_addr / data_wr_data  in  1 / 1 / ADDR_WIDTH / DATA_WIDTH  data request, data_we=1 write
- data_rd_data  out  DATA_WIDTH  read data, registered, valid while data_ack=1
- data_ack  out  1  one-cycle completion pulse
- mem_rd_en / mem_wr_en  out  1  to sram_fsm; at most one high
- mem_addr / mem_wr_data  out  ADDR_WIDTH / DATA_WIDTH  registered transaction fields
- mem_rd_data  in  DATA_WIDTH  from sram_fsm, valid when mem_done=1
- mem_done  in  1  sram_fsm completion pulse
- grant  out  2  current owner: 0 none, 1 boot, 2 inst, 3 data
- timeout_err  out  1  sticky watchdog flag

## Operation
- Requester rule: req held high with stable fields until ack seen; req dropped the cycle after ack.
- FSM states IDLE, BUSY, ACK.
- IDLE: arbitrate on current req levels.
  - boot_mode=1: boot_req -> grant boot, mem_wr_en. inst/data reqs ignored (remain pending).
  - boot_mode=0: boot_req ignored. Only inst_req or only data_req -> that port. Both -> port not in last_grant (round-robin). last_grant resets to data, so inst wins the first tie.
  - On grant: latch addr/wr_data/direction into mem_* regs, update last_grant, load watchdog counter 0, go BUSY.
- BUSY: mem_rd_en or mem_wr_en held high. Counter increments each cycle.
  - mem_done=1: drop enables, capture mem_rd_data into winner's rd_data reg (reads only), go ACK.
  - Counter reaches TIMEOUT_CYCLES without mem_done: drop enables, winner's rd_data := all ones, timeout_err := 1, go ACK.
  - mem_done wins if coincident with timeout.
- ACK: winner's ack=1 for exactly one cycle; grant returns 0; go IDLE.
- boot_mode change during BUSY/ACK: current transaction completes unchanged; new value applies at next IDLE.
- inst_rd_data/data_rd_data hold last captured value until overwritten.
- mem_done outside BUSY ignored.
- Reset (any state): all outputs 0 (timeout_err, rd_data, mem_*, acks, grant = 0), FSM IDLE, last_grant=data, counter 0. In-flight transaction discarded, no ack.

## Timing
- All outputs registered; no combinational path from inputs to outputs.
- Cycle 0: req high in IDLE. Cycle 1: BUSY, mem_*_en high. mem_done in cycle k (k>=1) -> ack in cycle k+1. Minimum req-to-ack latency 2 cycles; back-to-back transactions every 3 cycles minimum (IDLE/BUSY/ACK).
- Watchdog: mem enable high for TIMEOUT_CYCLES cycles, ack in following cycle.

## Test plan
- Boot write: boot_mode=1, boot_req, addr=0x00010, data=0xDEADBEEF, sram_fsm model done after 3 cycles -> mem_wr_en high 3 cycles with mem_addr=0x00010, boot_ack pulse at cycle 4, grant=1 during BUSY.
- Round-robin: boot_mode=0, inst_req and data_req (read, 0x00100) held continuously -> grants alternate inst, data, inst, data; first grant inst; each port's rd_data matches model value.
- Mode gating: boot_mode=1 with inst_req high -> no mem activity for 20 cycles; set boot_mode=0 -> inst served, inst_ack within 2+model latency cycles.
- Watchdog: TIMEOUT_CYCLES=8, model never asserts mem_done, data read -> enable high exactly 8 cycles, data_ack next cycle, data_rd_data=0xFFFFFFFF, timeout_err=1 and stays 1 across following good transaction.
- Reset mid-op: assert rst_n=0 during BUSY -> mem_rd_en, grant, acks drop immediately (async); after release, inst_req served first again, no stale ack.
- Minimum latency: mem_done in first BUSY cycle -> ack in cycle 2, next request granted in cycle 3.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one sram_fsm port between boot, instruction and data requesters.
// Round-robin between inst/data, req/ack handshake, sticky bus-hang watchdog. Rev 1.0
`default_nettype none

module sram_port_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 20,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  boot_mode_i,
  input  logic                  boot_req_i,
  input  logic [ADDR_WIDTH-1:0] boot_addr_i,
  input  logic [DATA_WIDTH-1:0] boot_wr_data_i,
  output logic                  boot_ack_o,
  input  logic                  inst_req_i,
  input  logic [ADDR_WIDTH-1:0] inst_addr_i,
  output logic [DATA_WIDTH-1:0] inst_rd_data_o,
  output logic                  inst_ack_o,
  input  logic                  data_req_i,
  input  logic                  data_we_i,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic [DATA_WIDTH-1:0] data_wr_data_i,
  output logic [DATA_WIDTH-1:0] data_rd_data_o,
  output logic                  data_ack_o,
  output logic                  mem_rd_en_o,
  output logic                  mem_wr_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wr_data_o,
  input  logic [DATA_WIDTH-1:0] mem_rd_data_i,
  input  logic                  mem_done_i,
  output logic [1:0]            grant_o,
  output logic                  timeout_err_o
);

  localparam int unsigned      c_CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(TIMEOUT_CYCLES);
  localparam logic [1:0]       c_G_NONE  = 2'd0;
  localparam logic [1:0]       c_G_BOOT  = 2'd1;
  localparam logic [1:0]       c_G_INST  = 2'd2;
  localparam logic [1:0]       c_G_DATA  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            owner_q, owner_d;
  logic                  last_inst_q, last_inst_d;
  logic [c_CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wr_data_q, mem_wr_data_d;
  logic                  mem_rd_en_q, mem_rd_en_d;
  logic                  mem_wr_en_q, mem_wr_en_d;
  logic [1:0]            grant_q, grant_d;
  logic                  boot_ack_q, boot_ack_d;
  logic                  inst_ack_q, inst_ack_d;
  logic                  data_ack_q, data_ack_d;
  logic [DATA_WIDTH-1:0] inst_rd_q, inst_rd_d;
  logic [DATA_WIDTH-1:0] data_rd_q, data_rd_d;
  logic                  tout_q, tout_d;

  logic                  w_pick_boot;
  logic                  w_pick_inst;
  logic                  w_pick_data;
  logic [c_CNT_W-1:0]    w_cnt_inc;

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_inst_d   = last_inst_q;
    cnt_d         = cnt_q;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    mem_rd_en_d   = mem_rd_en_q;
    mem_wr_en_d   = mem_wr_en_q;
    grant_d       = grant_q;
    boot_ack_d    = 1'b0;
    inst_ack_d    = 1'b0;
    data_ack_d    = 1'b0;
    inst_rd_d     = inst_rd_q;
    data_rd_d     = data_rd_q;
    tout_d        = tout_q;

    // On a tie the port that did not win last time is served.
    w_pick_boot = boot_mode_i && boot_req_i;
    w_pick_inst = !boot_mode_i && inst_req_i && (!data_req_i || !last_inst_q);
    w_pick_data = !boot_mode_i && data_req_i && !w_pick_inst;
    w_cnt_inc   = cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (w_pick_boot) begin
          owner_d       = c_G_BOOT;
          mem_addr_d    = boot_addr_i;
          mem_wr_data_d = boot_wr_data_i;
          mem_wr_en_d   = 1'b1;
        end else if (w_pick_inst) begin
          owner_d     = c_G_INST;
          mem_addr_d  = inst_addr_i;
          mem_rd_en_d = 1'b1;
          last_inst_d = 1'b1;
        end else if (w_pick_data) begin
          owner_d       = c_G_DATA;
          mem_addr_d    = data_addr_i;
          mem_wr_data_d = data_wr_data_i;
          mem_rd_en_d   = !data_we_i;
          mem_wr_en_d   = data_we_i;
          last_inst_d   = 1'b0;
        end
        if (w_pick_boot || w_pick_inst || w_pick_data) begin
          grant_d = owner_d;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end

      S_BUSY: begin
        if (mem_done_i || (w_cnt_inc == c_TIMEOUT)) begin
          mem_rd_en_d = 1'b0;
          mem_wr_en_d = 1'b0;
          grant_d     = c_G_NONE;
          boot_ack_d  = (owner_q == c_G_BOOT);
          inst_ack_d  = (owner_q == c_G_INST);
          data_ack_d  = (owner_q == c_G_DATA);
          state_d     = S_ACK;
          if (mem_done_i) begin
            if (mem_rd_en_q && owner_q == c_G_INST) inst_rd_d = mem_rd_data_i;
            if (mem_rd_en_q && owner_q == c_G_DATA) data_rd_d = mem_rd_data_i;
          end else begin
            // Watchdog abort: poison the read data so software can spot it.
            tout_d = 1'b1;
            if (owner_q == c_G_INST) inst_rd_d = '1;
            if (owner_q == c_G_DATA) data_rd_d = '1;
          end
        end else begin
          cnt_d = w_cnt_inc;
        end
      end

      S_ACK: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      owner_q       <= c_G_NONE;
      last_inst_q   <= 1'b0;
      cnt_q         <= '0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      mem_rd_en_q   <= 1'b0;
      mem_wr_en_q   <= 1'b0;
      grant_q       <= c_G_NONE;
      boot_ack_q    <= 1'b0;
      inst_ack_q    <= 1'b0;
      data_ack_q    <= 1'b0;
      inst_rd_q     <= '0;
      data_rd_q     <= '0;
      tout_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_inst_q   <= last_inst_d;
      cnt_q         <= cnt_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      mem_rd_en_q   <= mem_rd_en_d;
      mem_wr_en_q   <= mem_wr_en_d;
      grant_q       <= grant_d;
      boot_ack_q    <= boot_ack_d;
      inst_ack_q    <= inst_ack_d;
      data_ack_q    <= data_ack_d;
      inst_rd_q     <= inst_rd_d;
      data_rd_q     <= data_rd_d;
      tout_q        <= tout_d;
    end
  end

  assign boot_ack_o     = boot_ack_q;
  assign inst_ack_o     = inst_ack_q;
  assign data_ack_o     = data_ack_q;
  assign inst_rd_data_o = inst_rd_q;
  assign data_rd_data_o = data_rd_q;
  assign mem_rd_en_o    = mem_rd_en_q;
  assign mem_wr_en_o    = mem_wr_en_q;
  assign mem_addr_o     = mem_addr_q;
  assign mem_wr_data_o  = mem_wr_data_q;
  assign grant_o        = grant_q;
  assign timeout_err_o  = tout_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: vector table plus multi-cycle sequences for sram_port_arbiter.
// A behavioural sram_fsm answers with {12'hABC, addr} after a programmable latency. Rev 1.0
`default_nettype none

module tb_sram_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          boot_mode = 1'b0, boot_req = 1'b0;
  logic [AW-1:0] boot_addr = 20'h00010;
  logic [DW-1:0] boot_wr_data = 32'hDEADBEEF;
  logic          boot_ack;
  logic          inst_req = 1'b0;
  logic [AW-1:0] inst_addr = 20'h00040;
  logic [DW-1:0] inst_rd_data;
  logic          inst_ack;
  logic          data_req = 1'b0, data_we = 1'b0;
  logic [AW-1:0] data_addr = 20'h00100;
  logic [DW-1:0] data_wr_data = '0;
  logic [DW-1:0] data_rd_data;
  logic          data_ack;
  logic          mem_rd_en, mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data;
  logic [DW-1:0] mem_rd_data;
  logic          mem_done = 1'b0;
  logic [1:0]    grant;
  logic          timeout_err;

  sram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .boot_mode_i(boot_mode),
    .boot_req_i(boot_req), .boot_addr_i(boot_addr), .boot_wr_data_i(boot_wr_data), .boot_ack_o(boot_ack),
    .inst_req_i(inst_req), .inst_addr_i(inst_addr), .inst_rd_data_o(inst_rd_data), .inst_ack_o(inst_ack),
    .data_req_i(data_req), .data_we_i(data_we), .data_addr_i(data_addr), .data_wr_data_i(data_wr_data),
    .data_rd_data_o(data_rd_data), .data_ack_o(data_ack),
    .mem_rd_en_o(mem_rd_en), .mem_wr_en_o(mem_wr_en), .mem_addr_o(mem_addr), .mem_wr_data_o(mem_wr_data),
    .mem_rd_data_i(mem_rd_data), .mem_done_i(mem_done), .grant_o(grant), .timeout_err_o(timeout_err)
  );

  always #5 clk = ~clk;

  // sram_fsm model: mem_done in the lat-th enabled cycle; lat = 0 never answers.
  int lat = 2;
  int busy_cnt = 0;
  assign mem_rd_data = {12'hABC, mem_addr};
  always @(negedge clk) begin
    if (mem_rd_en || mem_wr_en) begin
      busy_cnt = busy_cnt + 1;
      mem_done = (lat != 0) && (busy_cnt == lat);
    end else begin
      busy_cnt = 0;
      mem_done = 1'b0;
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [1:0]  port;
    logic        crd;
    logic [31:0] rdd;
  } exp_t;
  exp_t sb[$];
  exp_t mexp;
  logic [1:0] mport;

  // Ack monitor: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && (boot_ack || inst_ack || data_ack)) begin
      chk((int'(boot_ack) + int'(inst_ack) + int'(data_ack)) == 1, "ack_onehot",
          {29'd0, boot_ack, inst_ack, data_ack}, 32'd1);
      mport = boot_ack ? 2'd1 : (inst_ack ? 2'd2 : 2'd3);
      chk(sb.size() != 0, "ack_expected", 32'(mport), 32'd0);
      if (sb.size() != 0) begin
        mexp = sb.pop_front();
        chk(mport == mexp.port, "ack_port", 32'(mport), 32'(mexp.port));
        if (mexp.crd && mexp.port == 2'd2)
          chk(inst_rd_data == mexp.rdd, "inst_rd_data", inst_rd_data, mexp.rdd);
        if (mexp.crd && mexp.port == 2'd3)
          chk(data_rd_data == mexp.rdd, "data_rd_data", data_rd_data, mexp.rdd);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until an ack shows; returns enabled-cycle count and ack cycle (relative).
  task automatic run(output int en_cyc, output int ack_cyc);
    en_cyc  = 0;
    ack_cyc = -1;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (mem_rd_en || mem_wr_en) en_cyc++;
      if (boot_ack || inst_ack || data_ack) begin
        ack_cyc = c;
        break;
      end
    end
    chk(ack_cyc >= 0, "ack_within_bound", 32'(ack_cyc), 32'd1);
  endtask

  task automatic drop_reqs();
    boot_req = 1'b0;
    inst_req = 1'b0;
    data_req = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb.delete();
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [AW-1:0] port_addr(input logic [1:0] g);
    case (g)
      2'd1:    return 20'h00010;
      2'd2:    return 20'h00040;
      default: return 20'h00100;
    endcase
  endfunction

  typedef struct packed {
    logic        bm, breq, ireq, dreq, dwe;
    logic [1:0]  g;
    logic        rd, wr, crd;
    logic [31:0] rdd;
  } vec_t;
  vec_t vecs[9];
  vec_t v;
  logic [1:0] rr_seq[4];

  initial begin
    int en, ac, n;
    logic [1:0] prev;

    //             bm  breq ireq dreq dwe  g     rd   wr   crd  rdd
    vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 1'b1, 32'hABC00040};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 1'b1, 1'b0, 1'b1, 32'hABC00100};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 32'hABC00040};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b1, 32'hABC00040};
    vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 1'b1, 1'b0, 1'b1, 32'hABC00100};
    rr_seq = '{2'd2, 2'd3, 2'd2, 2'd3};

    // Reset values, sampled while reset is held.
    tick();
    tick();
    chk(grant == 2'd0 && !mem_rd_en && !mem_wr_en, "rst_grant_en", {29'd0, grant, mem_rd_en}, 32'd0);
    chk(mem_addr == '0 && mem_wr_data == '0, "rst_mem_fields", mem_wr_data, 32'd0);
    chk(!boot_ack && !inst_ack && !data_ack && !timeout_err, "rst_acks_tout",
        {28'd0, boot_ack, inst_ack, data_ack, timeout_err}, 32'd0);
    chk(inst_rd_data == '0 && data_rd_data == '0, "rst_rd_data", inst_rd_data | data_rd_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Boot write with a 3-cycle sram_fsm.
    lat = 3;
    boot_mode = 1'b1;
    boot_req = 1'b1;
    sb.push_back(exp_t'{2'd1, 1'b0, 32'h0});
    tick();
    chk(grant == 2'd1 && mem_wr_en && !mem_rd_en, "boot_grant_wr", {29'd0, grant, mem_wr_en}, 32'h3);
    chk(mem_addr == 20'h00010, "boot_mem_addr", 32'(mem_addr), 32'h10);
    chk(mem_wr_data == 32'hDEADBEEF, "boot_mem_wr_data", mem_wr_data, 32'hDEADBEEF);
    run(en, ac);
    chk(en + 1 == 3, "boot_wr_en_cycles", 32'(en + 1), 32'd3);
    chk(ac + 1 == 4, "boot_ack_cycle", 32'(ac + 1), 32'd4);
    drop_reqs();
    tick();

    // Arbitration vector table.
    lat = 2;
    for (int i = 0; i < 9; i++) begin
      v = vecs[i];
      boot_mode = v.bm;
      boot_req  = v.breq;
      inst_req  = v.ireq;
      data_req  = v.dreq;
      data_we   = v.dwe;
      data_wr_data = 32'h12345600 + 32'(i);
      if (v.g != 2'd0) sb.push_back(exp_t'{v.g, v.crd, v.rdd});
      tick();
      chk(grant == v.g, "vec_grant", 32'(grant), 32'(v.g));
      chk(mem_rd_en == v.rd, "vec_rd_en", 32'(mem_rd_en), 32'(v.rd));
      chk(mem_wr_en == v.wr, "vec_wr_en", 32'(mem_wr_en), 32'(v.wr));
      if (v.g != 2'd0) begin
        chk(mem_addr == port_addr(v.g), "vec_mem_addr", 32'(mem_addr), 32'(port_addr(v.g)));
        if (v.wr)
          chk(mem_wr_data == (v.g == 2'd1 ? boot_wr_data : data_wr_data), "vec_mem_wr_data",
              mem_wr_data, (v.g == 2'd1 ? boot_wr_data : data_wr_data));
        run(en, ac);
        chk(ac == 2, "vec_ack_cycle", 32'(ac), 32'd2);
      end else begin
        repeat (3) tick();
        chk(grant == 2'd0 && !mem_rd_en && !mem_wr_en, "vec_stays_idle", {29'd0, grant, mem_rd_en}, 32'd0);
      end
      drop_reqs();
      tick();
    end

    // Round-robin with both ports held high from reset.
    do_reset();
    boot_mode = 1'b0;
    data_we = 1'b0;
    inst_req = 1'b1;
    data_req = 1'b1;
    n = 0;
    prev = 2'd0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (grant != 2'd0 && prev == 2'd0 && n < 4) begin
        chk(grant == rr_seq[n], "rr_grant", 32'(grant), 32'(rr_seq[n]));
        sb.push_back(exp_t'{rr_seq[n], 1'b1, (rr_seq[n] == 2'd2) ? 32'hABC00040 : 32'hABC00100});
        n++;
      end
      prev = grant;
      if (n == 4 && (inst_ack || data_ack)) break;
    end
    chk(n == 4, "rr_grant_count", 32'(n), 32'd4);
    drop_reqs();
    tick();

    // Mode gating: inst request parked under boot mode.
    do_reset();
    boot_mode = 1'b1;
    inst_req = 1'b1;
    en = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (mem_rd_en || mem_wr_en) en++;
    end
    chk(en == 0, "gate_no_mem_activity", 32'(en), 32'd0);
    boot_mode = 1'b0;
    sb.push_back(exp_t'{2'd2, 1'b1, 32'hABC00040});
    run(en, ac);
    chk(ac == lat + 1, "gate_inst_ack_latency", 32'(ac), 32'(lat + 1));
    drop_reqs();
    tick();

    // Watchdog: sram_fsm never answers a data read.
    lat = 0;
    data_we = 1'b0;
    data_req = 1'b1;
    sb.push_back(exp_t'{2'd3, 1'b1, 32'hFFFFFFFF});
    run(en, ac);
    chk(en == 8, "wd_enable_cycles", 32'(en), 32'd8);
    chk(ac == 9, "wd_ack_cycle", 32'(ac), 32'd9);
    chk(timeout_err == 1'b1, "wd_timeout_err", 32'(timeout_err), 32'd1);
    drop_reqs();
    tick();
    lat = 2;
    inst_req = 1'b1;
    sb.push_back(exp_t'{2'd2, 1'b1, 32'hABC00040});
    run(en, ac);
    drop_reqs();
    tick();
    chk(timeout_err == 1'b1, "wd_timeout_sticky", 32'(timeout_err), 32'd1);

    // Asynchronous reset in the middle of a transaction.
    lat = 0;
    inst_req = 1'b1;
    repeat (3) tick();
    chk(mem_rd_en && grant == 2'd2, "mid_busy_before_reset", {30'd0, grant}, 32'd2);
    rst_n = 1'b0;
    #1;
    chk(!mem_rd_en && grant == 2'd0 && !inst_ack, "mid_async_drop", {29'd0, grant, mem_rd_en}, 32'd0);
    chk(timeout_err == 1'b0, "mid_tout_cleared", 32'(timeout_err), 32'd0);
    sb.delete();
    data_req = 1'b1;
    lat = 1;
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    prev = 2'd0;
    for (int c = 0; c < 5 && prev == 2'd0; c++) begin
      tick();
      prev = grant;
    end
    chk(prev == 2'd2, "mid_first_grant_inst", 32'(prev), 32'd2);
    sb.push_back(exp_t'{2'd2, 1'b1, 32'hABC00040});
    run(en, ac);
    drop_reqs();
    tick();

    // Minimum latency and back-to-back spacing.
    lat = 1;
    data_we = 1'b0;
    data_req = 1'b1;
    inst_req = 1'b1;
    sb.push_back(exp_t'{2'd3, 1'b1, 32'hABC00100});
    sb.push_back(exp_t'{2'd2, 1'b1, 32'hABC00040});
    run(en, ac);
    chk(ac == 2, "minlat_ack_cycle", 32'(ac), 32'd2);
    data_req = 1'b0;
    tick();
    chk(grant == 2'd0, "minlat_idle_cycle3", 32'(grant), 32'd0);
    tick();
    chk(grant == 2'd2 && mem_rd_en, "minlat_next_busy_cycle4", 32'(grant), 32'd2);
    run(en, ac);
    chk(ac == 1, "minlat_second_ack", 32'(ac), 32'd1);
    drop_reqs();
    repeat (2) tick();
    chk(sb.size() == 0, "scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
